// File: rtl/billing_pkg.sv
// Shared types and constants for the call-billing meter and its record logger.
package billing_pkg;

    localparam logic [1:0] TYPE_LOCAL = 2'b01;
    localparam logic [1:0] TYPE_LONG  = 2'b10;

    localparam int TIME_W  = 9;
    localparam int MONEY_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLOSE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]         rtype;
        logic [TIME_W-1:0]  minutes;
        logic [MONEY_W-1:0] charge;
        logic               cut;
    } rec_t;

endpackage

// File: rtl/bcd_sub11.sv
// 3-digit BCD subtractor (diff = a - b) with borrow-out; hundreds digit is 3 bits.
// Purely combinational, no latency and no flow control.
module bcd_sub11
    import billing_pkg::*;
(
    input  logic [MONEY_W-1:0] a,
    input  logic [MONEY_W-1:0] b,
    output logic [MONEY_W-1:0] diff,
    output logic               borrow
);

    logic [4:0] units;
    logic [4:0] tens;
    logic [3:0] hundreds;

    always_comb begin
        diff     = '0;
        units    = {1'b0, a[3:0]} - {1'b0, b[3:0]};
        diff[3:0] = units[4] ? (units[3:0] + 4'd10) : units[3:0];

        tens     = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, units[4]};
        diff[7:4] = tens[4] ? (tens[3:0] + 4'd10) : tens[3:0];

        // Hundreds is plain binary: a negative result just means the balance rose.
        hundreds   = {1'b0, a[10:8]} - {1'b0, b[10:8]} - {3'b0, tens[4]};
        diff[10:8] = hundreds[2:0];
        borrow     = hundreds[3];
    end

endmodule

// File: rtl/call_record_logger.sv
// Builds one record per billed call and queues it in a show-ahead FIFO.
// Record pushed one cycle after calling drops; full FIFO drops the record and sets sticky overflow unless popped that cycle.
module call_record_logger
    import billing_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               calling,
    input  logic [1:0]         type_in,
    input  logic               write,
    input  logic               cut,
    input  logic [TIME_W-1:0]  meter_time,
    input  logic [MONEY_W-1:0] meter_money,
    input  logic               rd_en,
    output logic               rec_valid,
    output logic [1:0]         rec_type,
    output logic [TIME_W-1:0]  rec_minutes,
    output logic [MONEY_W-1:0] rec_charge,
    output logic               rec_cut,
    output logic [AW:0]        count,
    output logic               overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t             state;
    logic [1:0]         call_type;
    logic [MONEY_W-1:0] start_money;
    logic [MONEY_W-1:0] last_money;
    logic [TIME_W-1:0]  last_time;
    logic               min_seen;
    logic               cut_seen;

    logic [MONEY_W-1:0] diff;
    logic               borrow;
    rec_t               new_rec;

    rec_t               mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_r;
    logic               full;
    logic               push;
    logic               push_ok;
    logic               pop;
    rec_t               head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            call_type   <= '0;
            start_money <= '0;
            last_money  <= '0;
            last_time   <= '0;
            min_seen    <= 1'b0;
            cut_seen    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (calling) begin
                        start_money <= meter_money;
                        call_type   <= type_in;
                        last_time   <= '0;
                        last_money  <= '0;
                        min_seen    <= 1'b0;
                        cut_seen    <= 1'b0;
                        state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // Events on the cycle calling drops still belong to this call.
                    if (write) begin
                        last_time  <= meter_time;
                        last_money <= meter_money;
                        min_seen   <= 1'b1;
                    end
                    if (cut) begin
                        cut_seen <= 1'b1;
                    end
                    if (!calling) begin
                        state <= ST_CLOSE;
                    end
                end
                ST_CLOSE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bcd_sub11 u_charge (
        .a      (start_money),
        .b      (last_money),
        .diff   (diff),
        .borrow (borrow)
    );

    always_comb begin
        new_rec         = '0;
        new_rec.rtype   = call_type;
        new_rec.minutes = last_time;
        new_rec.charge  = borrow ? '0 : diff;
        new_rec.cut     = cut_seen;
    end

    assign full    = (count_r == FULL_CNT);
    assign push    = (state == ST_CLOSE) && min_seen;
    assign pop     = rd_en && (count_r != '0);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign rec_valid   = (count_r != '0);
    assign head        = rec_valid ? mem[rd_ptr] : '0;
    assign rec_type    = head.rtype;
    assign rec_minutes = head.minutes;
    assign rec_charge  = head.charge;
    assign rec_cut     = head.cut;
    assign count       = count_r;

endmodule

// File: doc/call_record_logger.md
Name: call_record_logger

Overview:
- Consumer side of the call-billing meter.
- Watches the meter's `calling`, `write`, `cut`, BCD elapsed-minutes and BCD balance outputs.
- When each call ends, it builds one call record: type, billed minutes, BCD charge, cut flag.
- Records are queued in a small FIFO, which a display/printer unit drains with a show-ahead read port.

Parameters:
DEPTH, 8, record FIFO entries (power of 2)
AW, 3, log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
calling  in  1  call in progress (from meter)
type_in  in  2  call type: 2'b01 local, 2'b10 long-distance
write  in  1  meter billed one minute this cycle
cut  in  1  meter forced disconnect
meter_time  in  9  BCD minutes: [8] hundreds, [7:4] tens, [3:0] units
meter_money  in  11  BCD balance: [10:8] hundreds, [7:4] tens, [3:0] units
rd_en  in  1  pop head record
rec_valid  out  1  FIFO non-empty; rec_* valid
rec_type  out  2  head record type
rec_minutes  out  9  head record billed minutes (BCD)
rec_charge  out  11  head record charge (BCD)
rec_cut  out  1  head record ended by cut
count  out  AW+1  records held, 0..DEPTH
overflow  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; state IDLE; internal latches cleared.
  - `overflow` clears only on `rst`.
- FSM states: IDLE, ACTIVE, CLOSE.
- IDLE, when `calling==1`:
  - Capture `start_money=meter_money` and `call_type=type_in`.
  - Clear `last_time`, `last_money` and `min_seen`; clear `cut_seen`.
  - Go to ACTIVE.
- ACTIVE:
  - When `write==1`, latch `last_time=meter_time` and `last_money=meter_money`, and set `min_seen=1`.
  - When `cut==1`, set `cut_seen=1`.
  - When `calling==0`, go to CLOSE. A `write` or `cut` in that same cycle is still latched.
  - Changes on `type_in` during ACTIVE are ignored.
- CLOSE (exactly one cycle):
  - If `min_seen==1`, push the record {call_type, last_time, charge, cut_seen}.
  - Zero-minute calls (no `write`) are not logged.
  - Next state is IDLE unconditionally.
  - A call restarting while in CLOSE is picked up by IDLE on the following cycle, because IDLE is level-sensitive.
- Latency: with `calling` sampled low at edge k, the push happens at edge k+1, and `rec_valid`/`count` update after edge k+1.
- Charge = start_money − last_money, computed as BCD subtraction:
  - Units and tens digits subtract 0..9 with borrow; the hundreds digit is 3 bits.
  - If the final borrow is set (balance rose), charge = 0 and the record is still pushed.
  - Computed combinationally in CLOSE.
- FIFO behaviour:
  - Show-ahead: `rec_*` reflect the head entry whenever `rec_valid==1`.
  - `rd_en` with `rec_valid==1` pops at that edge; `rd_en` while empty is ignored.
  - Push while full with no pop: the record is dropped, `overflow` is set, `count` stays DEPTH.
  - Push and pop in the same cycle: both take effect (full FIFO accepts the push), and `count` is unchanged.
  - Pointers are AW bits and wrap modulo DEPTH.
- Reset mid-call: the in-progress record is lost and the FIFO is emptied. If `calling` is still high, a new call starts the cycle after `rst` deasserts, using the then-current balance.

Decomposition:
- Shared package `billing_pkg`:
  - Call type constants TYPE_LOCAL=2'b01 and TYPE_LONG=2'b10.
  - BCD widths TIME_W=9 and MONEY_W=11.
  - FSM state encoding.
  - Record struct {type, minutes, charge, cut}.
- Sub-module `bcd_sub11`: combinational 3-digit BCD subtractor with borrow-out, reusable by the meter and recharge logic.
- The FIFO stays inline.

Test Plan:
1. Local call, start 0x500, writes (time 0x001, money 0x497) then (0x002, 0x494), `calling` drops → one record: type 01, minutes 0x002, charge 0x006, cut 0; `rec_valid` and `count`=1 one cycle after CLOSE.
2. Long-distance call, start 0x100, one write (0x001, 0x094) → charge 0x006, exercising a borrow across all digits.
3. `calling` high 30 cycles with no write, then low → no record; `count` stays 0.
4. Nine 1-minute calls with no reads → `count`=8, `overflow`=1, records 1–8 intact; `rd_en` ×8 returns them in order, then `rec_valid`=0.
5. FIFO full, `rd_en` held during the CLOSE push → `count` stays 8, `overflow` stays 0, head advances.
6. Call with `cut` pulse and a final write in the same cycle `calling` drops → `rec_cut`=1 and last minute included. Separately, `rst` mid-call → outputs 0, and a new call is captured after release.
